// File: rtl/proc_scheduler.sv
// Round-robin process scheduler: time-slices contexts and requests PC switches.
// Optional macro PROC_SCHED_YIELD_EN adds a voluntary yield input.
module proc_scheduler #(
    parameter int NUM_PROC  = 4,
    parameter int ADDR_W    = 10,
    parameter int QUANTUM   = 16,
    parameter int PART_SIZE = 256,
    localparam int IDX_W    = (NUM_PROC > 2) ? $clog2(NUM_PROC) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              step,
    input  logic [ADDR_W-1:0] cur_pc,
    input  logic              ctx_wr,
    input  logic [IDX_W-1:0]  ctx_idx,
    input  logic [ADDR_W-1:0] ctx_pc,
    input  logic              ctx_ready,
`ifdef PROC_SCHED_YIELD_EN
    input  logic              yield,
`endif
    input  logic              ack,
    output logic              preempt,
    output logic [ADDR_W-1:0] next_pc,
    output logic [IDX_W-1:0]  proc_index,
    output logic [31:0]       shift_amount,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SAVE,
        SELECT,
        SWITCH
    } state_t;

    state_t              state;
    logic [15:0]         counter;
    logic [IDX_W-1:0]    sel;
    logic                from_idle;
    logic [NUM_PROC-1:0] ready;
    logic [ADDR_W-1:0]   ctx_table [NUM_PROC];

    logic [IDX_W-1:0]    pick;
    logic                found;
    logic                give_up;

    // Coming out of IDLE the retained process gets first pick; after a
    // save it is checked last so the others get their turn.
    always_comb begin
        int k;
        k     = 0;
        pick  = proc_index;
        found = 1'b0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            k = int'(proc_index) + i + (from_idle ? 0 : 1);
            if (k >= NUM_PROC) k = k - NUM_PROC;
            if (ready[k]) begin
                pick  = IDX_W'(k);
                found = 1'b1;
            end
        end
    end

`ifdef PROC_SCHED_YIELD_EN
    assign give_up = !ready[proc_index] || yield;
`else
    assign give_up = !ready[proc_index];
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            sel          <= '0;
            from_idle    <= 1'b0;
            ready        <= '0;
            preempt      <= 1'b0;
            next_pc      <= '0;
            proc_index   <= '0;
            shift_amount <= '0;
            for (int i = 0; i < NUM_PROC; i++) ctx_table[i] <= '0;
        end else begin
            if (!enable) begin
                state   <= IDLE;
                preempt <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (|ready) begin
                            state     <= SELECT;
                            from_idle <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (give_up) begin
                            state <= SAVE;
                        end else if (step) begin
                            if (counter == 16'(QUANTUM - 1)) state <= SAVE;
                            else counter <= counter + 16'd1;
                        end
                    end
                    SAVE: begin
                        ctx_table[proc_index] <= cur_pc;
                        from_idle             <= 1'b0;
                        state                 <= SELECT;
                    end
                    SELECT: begin
                        if (found) begin
                            sel     <= pick;
                            next_pc <= ctx_table[pick];
                            preempt <= 1'b1;
                            state   <= SWITCH;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    SWITCH: begin
                        if (ack) begin
                            proc_index   <= sel;
                            shift_amount <= 32'(sel) * 32'(PART_SIZE);
                            counter      <= '0;
                            preempt      <= 1'b0;
                            state        <= RUN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            // Kernel writes land last so they override a same-cycle save.
            if (ctx_wr && (int'(ctx_idx) < NUM_PROC)) begin
                ctx_table[ctx_idx] <= ctx_pc;
                ready[ctx_idx]     <= ctx_ready;
            end
        end
    end

endmodule

// File: tb/tb_proc_scheduler.sv
// Scoreboard bench for proc_scheduler: expected switches queued, checked on preempt.
module tb_proc_scheduler;

    localparam int NP = 4;
    localparam int AW = 10;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable, step, ctx_wr, ctx_ready, ack, yield;
    logic [AW-1:0] cur_pc, ctx_pc;
    logic [IW-1:0] ctx_idx;
    logic          preempt, busy;
    logic [AW-1:0] next_pc;
    logic [IW-1:0] proc_index;
    logic [31:0]   shift_amount;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t sb[$];

    proc_scheduler #(
        .NUM_PROC(NP), .ADDR_W(AW), .QUANTUM(4), .PART_SIZE(256)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .step(step),
        .cur_pc(cur_pc), .ctx_wr(ctx_wr), .ctx_idx(ctx_idx),
        .ctx_pc(ctx_pc), .ctx_ready(ctx_ready),
`ifdef PROC_SCHED_YIELD_EN
        .yield(yield),
`endif
        .ack(ack), .preempt(preempt), .next_pc(next_pc),
        .proc_index(proc_index), .shift_amount(shift_amount), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int idx, input int pc, input logic rdy);
        ctx_wr    = 1'b1;
        ctx_idx   = IW'(idx);
        ctx_pc    = AW'(pc);
        ctx_ready = rdy;
        @(negedge clk);
        ctx_wr = 1'b0;
    endtask

    task automatic run_steps(input int n, input int pc);
        cur_pc = AW'(pc);
        step   = 1'b1;
        repeat (n) @(negedge clk);
        step = 1'b0;
    endtask

    task automatic wait_preempt(input string tag);
        int n = 0;
        while (!preempt && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rise"}, 32'(preempt), 32'd1);
    endtask

    task automatic wait_switch(input string tag, input int ack_dly);
        exp_t e;
        wait_preempt(tag);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_pc"}, 32'(next_pc), 32'(e.pc));
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            check({tag, "_hold_pre"}, 32'(preempt), 32'd1);
            check({tag, "_hold_pc"}, 32'(next_pc), 32'(e.pc));
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check({tag, "_idx"}, 32'(proc_index), 32'(e.idx));
        check({tag, "_shift"}, shift_amount, 32'(e.idx) * 32'd256);
        check({tag, "_drop"}, 32'(preempt), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; enable = 1'b0; step = 1'b0; ctx_wr = 1'b0;
        ctx_ready = 1'b0; ack = 1'b0; yield = 1'b0;
        cur_pc = '0; ctx_pc = '0; ctx_idx = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_pre", 32'(preempt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idx", 32'(proc_index), 32'd0);
        check("rst_shift", shift_amount, 32'd0);
        check("rst_npc", 32'(next_pc), 32'd0);

        // first dispatch from idle, then expiry hands over to ctx1
        load(0, 'h010, 1'b1);
        load(1, 'h080, 1'b1);
        enable = 1'b1;
        sb.push_back('{pc: AW'('h010), idx: 2'd0});
        wait_switch("boot", 0);
        check("run_busy", 32'(busy), 32'd1);
        sb.push_back('{pc: AW'('h080), idx: 2'd1});
        run_steps(3, 'h014);
        check("no_early", 32'(preempt), 32'd0);
        run_steps(1, 'h014);
        wait_switch("rr01", 0);

        // only ctx1 and ctx3 ready: 1 -> 3 -> wrap to 1
        load(0, 'h010, 1'b0);
        load(3, 'h300, 1'b1);
        sb.push_back('{pc: AW'('h300), idx: 2'd3});
        run_steps(4, 'h0A0);
        wait_switch("rr13", 0);
        sb.push_back('{pc: AW'('h0A0), idx: 2'd1});
        run_steps(4, 'h333);
        wait_switch("wrap", 0);

        // only current ready: reselects itself with saved pc
        load(3, 'h300, 1'b0);
        sb.push_back('{pc: AW'('h123), idx: 2'd1});
        run_steps(4, 'h123);
        wait_switch("self", 0);

        // delayed ack with step held high, then counter restart latency
        cur_pc = AW'('h155);
        step   = 1'b1;
        sb.push_back('{pc: AW'('h155), idx: 2'd1});
        wait_switch("hold", 5);
        n = 0;
        while (!preempt && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cnt_restart", 32'(n), 32'd6);
        sb.push_back('{pc: AW'('h155), idx: 2'd1});
        wait_switch("post", 0);
        step = 1'b0;

`ifdef PROC_SCHED_YIELD_EN
        run_steps(1, 'h1A0);
        yield = 1'b1;
        @(negedge clk);
        yield = 1'b0;
        n = 1;
        while (!preempt && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("yield_lat", 32'(n), 32'd3);
        sb.push_back('{pc: AW'('h1A0), idx: 2'd1});
        wait_switch("yield", 0);
`endif

        // termination of the running process
        load(0, 'h040, 1'b1);
        cur_pc = AW'('h111);
        sb.push_back('{pc: AW'('h040), idx: 2'd0});
        load(1, 'h3FF, 1'b0);
        wait_switch("term", 0);

        // kernel write during SAVE to the same slot wins
        run_steps(4, 'h0EE);
        load(0, 'h0AB, 1'b1);
        sb.push_back('{pc: AW'('h0AB), idx: 2'd0});
        wait_switch("wr_wins", 0);

        // nothing left ready -> back to idle without preempt
        load(0, 'h0AB, 1'b0);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pre", 32'(preempt), 32'd0);

        // enable drop mid-switch
        load(2, 'h200, 1'b1);
        wait_preempt("en");
        check("en_pc", 32'(next_pc), 32'h200);
        enable = 1'b0;
        @(negedge clk);
        check("en_pre", 32'(preempt), 32'd0);
        check("en_busy", 32'(busy), 32'd0);
        check("en_idx", 32'(proc_index), 32'd0);

        // async reset mid-switch
        enable = 1'b1;
        wait_preempt("ar");
        #2 reset = 1'b1;
        #1;
        check("ar_pre", 32'(preempt), 32'd0);
        check("ar_npc", 32'(next_pc), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
